lane_fifo_pause: RTL and testbench
==================================

# lane_fifo_pause

Per-lane elastic buffer that sits directly downstream of the lane striping/unstriping tree. It captures each `dataIn`/`validIn` byte the tree produces and holds it until the consumer pops it. It raises `pause` back toward the producer when occupancy crosses a programmable threshold, and flags any overflow with a sticky `error`. One instance is placed per output lane, all on the same fast clock.

## Interface
Parameters:
- `DATA_WIDTH`, 8: payload width per entry.
- `ADDR_WIDTH`, 3: pointer width; depth = 2^ADDR_WIDTH (8 entries by default).
- `ALMOST_FULL`, 6: `almost_full`/`pause` asserted when count >= this value; legal range 1..DEPTH.
- `ALMOST_EMPTY`, 1: `almost_empty` asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `dataIn`, input, DATA_WIDTH: byte from the upstream lane.
- `validIn`, input, 1: push request; `dataIn` is qualified by it.
- `pop`, input, 1: read request from the consumer.
- `dataOut`, output, DATA_WIDTH: registered read data.
- `validOut`, output, 1: one-cycle strobe marking a fresh `dataOut`.
- `count`, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `almost_full`, output, 1: count >= ALMOST_FULL.
- `almost_empty`, output, 1: count <= ALMOST_EMPTY.
- `pause`, output, 1: backpressure to the producer; identical to `almost_full`.
- `error`, output, 1: sticky overflow flag.

## Operation
- Storage: DEPTH x DATA_WIDTH register array; write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits, with natural wrap at DEPTH-1 to 0. `count` is a separate ADDR_WIDTH+1 register.
- Push accepted when `validIn` && (!`full` || `pop`). On acceptance: mem[wr_ptr] <= dataIn, wr_ptr++.
- Pop accepted when `pop` && !`empty`. On acceptance: dataOut <= mem[rd_ptr], validOut <= 1, rd_ptr++.
- No pop accepted: validOut <= 0 and dataOut holds its last value.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Simultaneous push and pop:
  - When full: both are accepted, count stays DEPTH, no error.
  - When empty: only the push is accepted. There is no fall-through, so validOut = 0 and count becomes 1.
- Overflow: `validIn` && `full` && !`pop` drops the byte. Pointers and memory are unchanged, and `error` <= 1. `error` stays set until reset.
- Pop on empty is ignored silently. It does not set `error`.
- Flags (`full`, `empty`, `almost_full`, `almost_empty`, `pause`) are combinational decodes of the registered `count` only. No input feeds any flag combinationally.
- Reset (asynchronous assert, deassert sampled at the next rising edge):
  - wr_ptr, rd_ptr, count, dataOut, validOut and error go to 0.
  - Memory contents are not cleared.
  - Reset asserted mid-transfer discards all buffered data immediately.
- Flag values during and after reset: `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `pause` = 0.

## Timing
- Write-to-read latency: a byte pushed at edge N can be popped at edge N+1 and appears on `dataOut` with `validOut` = 1 after edge N+1. Minimum latency is 2 edges from `validIn` to `validOut`.
- Pop-to-data latency: 1 cycle. Data is registered, so there is no combinational path from `pop` to `dataOut`.
- `validOut` is high for exactly one cycle per accepted pop. Back-to-back pops give continuous `validOut`.
- Flags update in the same cycle that `count` changes, i.e. right after the edge.
- `pause` takes effect one edge late: the producer sees it after the push that crossed the threshold. ALMOST_FULL < DEPTH therefore absorbs at least one in-flight byte.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy from 1 to DEPTH-1.

## Test plan
- **Reset:** hold `reset` = 0 with random inputs.
  - Required: all outputs at their reset values (`empty` = 1, `count` = 0, `dataOut` = 8'h00, `validOut` = 0, `error` = 0).
  - Release `reset`; the first push of 8'hFF gives `count` = 1 after that edge.
- **Ordering and wrap:** push 8'hFF, 8'hEE, 8'hDD, 8'hCC, then pop 4 times; repeat for 3 rounds so the pointers wrap.
  - Required: `dataOut` sequence FF, EE, DD, CC each round, `validOut` high 4 cycles per round, `empty` = 1 at the end of each round.
- **Threshold and full:** push 8 bytes 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44 with no pop.
  - Required: `pause` = 1 after the 6th push and `full` = 1, `count` = 8 after the 8th push.
  - Then push 8'h33 with no pop: `error` = 1, `count` stays 8.
  - Draining: the 8 pops return BB..44; 8'h33 never appears.
- **Simultaneous push and pop:**
  - At full: push 8'h12 with pop. Required: `dataOut` = oldest byte, `count` = 8, `error` unchanged.
  - At empty: push 8'h34 with pop. Required: `validOut` = 0, `count` = 1; the next pop returns 8'h34.
- **Pop on empty:** pop for 3 cycles with no data.
  - Required: `validOut` = 0, `dataOut` holds its previous value, `error` = 0, `count` = 0.
- **Mid-operation reset:** with 5 entries buffered, assert `reset` asynchronously between edges.
  - Required: `count` = 0 and `empty` = 1 immediately, without waiting for an edge.
  - After release, a push of 8'h77 then a pop returns 8'h77.

Source files
------------

// File: rtl/lane_fifo_pause.sv
// lane_fifo_pause
//   Per-lane elastic buffer behind the striping/unstriping tree. Bytes are
//   captured on validIn, held until popped, and returned on a registered
//   dataOut with a one-cycle validOut strobe. pause (== almost_full) throttles
//   the producer; error is a sticky overflow indicator.
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low reset
//   dataIn       - byte from the upstream lane
//   validIn      - push request qualifying dataIn
//   pop          - read request from the consumer
//   dataOut      - registered read data (holds when no pop is accepted)
//   validOut     - one-cycle strobe marking a fresh dataOut
//   count        - occupancy, 0..DEPTH
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= ALMOST_FULL
//   almost_empty - count <= ALMOST_EMPTY
//   pause        - backpressure, same as almost_full
//   error        - sticky overflow flag, cleared only by reset
module lane_fifo_pause #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  validIn,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  pause,
    output logic                  error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push_ok, pop_ok;

    // Flags decode only the registered count, never the inputs.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign pause        = almost_full;

    // A pop at full frees the slot the push lands in. A pop at empty is not
    // accepted, so a simultaneous push at empty does not fall through.
    assign push_ok = validIn && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Storage is intentionally not reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= dataIn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dataOut  <= '0;
            validOut <= 1'b0;
            error    <= 1'b0;
        end else begin
            validOut <= pop_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                dataOut <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Overflow drops the byte and latches the error until reset.
            if (validIn && full && !pop) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lane_fifo_pause.sv
// Directed bench for lane_fifo_pause with a queue-based scoreboard: bytes are
// pushed to the model queue as they are driven and popped when the DUT is
// expected to present them on dataOut.
module tb_lane_fifo_pause;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] dataOut;
    logic       validOut;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, pause, error;

    lane_fifo_pause dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .pop(pop),
        .dataOut(dataOut), .validOut(validOut), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .pause(pause), .error(error)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q[$];
    int         mcount = 0;
    logic       merr = 1'b0;
    logic [7:0] mdout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic exp_vout);
        chk("count", 32'(count), mcount);
        chk("full", 32'(full), 32'(mcount == 8));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 1));
        chk("pause", 32'(pause), 32'(mcount >= 6));
        chk("error", 32'(error), 32'(merr));
        chk("validOut", 32'(validOut), 32'(exp_vout));
        chk("dataOut", 32'(dataOut), 32'(mdout));
    endtask

    // Called at a falling edge: drive, clock once, then check at the next
    // falling edge against the model.
    task automatic step(input logic vin, input logic [7:0] din, input logic p);
        logic push_acc, pop_acc;
        validIn  = vin;
        dataIn   = din;
        pop      = p;
        push_acc = vin && (mcount < 8 || p);
        pop_acc  = p && (mcount > 0);
        if (vin && mcount == 8 && !p) merr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (pop_acc) mdout = q.pop_front();
        if (push_acc) q.push_back(din);
        mcount  = q.size();
        validIn = 1'b0;
        pop     = 1'b0;
        check_all(pop_acc);
    endtask

    task automatic model_reset();
        q.delete();
        mcount = 0;
        merr   = 1'b0;
        mdout  = 8'h00;
    endtask

    initial begin
        logic [7:0] pat [4];
        logic [7:0] fillb [8];
        pat   = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        fillb = '{8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44};

        // Reset held with random inputs
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            validIn = 1'($urandom);
            pop     = 1'($urandom);
            dataIn  = 8'($urandom);
            #1 check_all(1'b0);
        end
        @(negedge clk);
        validIn = 1'b0;
        pop     = 1'b0;
        reset   = 1'b1;

        // First push after release, then ordering and pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
            for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        end

        // Pop on empty: no strobe, dataOut holds CC, no error
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Push and pop together at empty: only the push lands
        step(1'b1, 8'h34, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Fill through the threshold to full, then overflow
        for (int i = 0; i < 8; i++) step(1'b1, fillb[i], 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Push and pop together at full: count stays 8
        step(1'b1, 8'h12, 1'b1);

        // Drain everything
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

        // Mid-operation asynchronous reset with 5 entries buffered
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_empty", 32'(empty), 1);
        model_reset();
        @(negedge clk);
        check_all(1'b0);
        reset = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
